// File: rtl/div88_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a start/busy/done handshake.
// Optional macro DIV88_EARLY_EXIT_EN: b==0 or a<b completes one edge after start without iterating.
module div88_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;
  logic             early;

  // The partial remainder stays below D, so only the trial value needs the extra bit.
  always_comb begin
    t      = {r_q, q_q[WIDTH-1]};
    ge     = (t >= {1'b0, d_q});
    r_step = ge ? (t[WIDTH-1:0] - d_q) : t[WIDTH-1:0];
    q_step = {q_q[WIDTH-2:0], ge};
  end

`ifdef DIV88_EARLY_EXIT_EN
  assign early = (b == '0) || (a < b);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      CALC: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          quo_d   = q_step;
          rem_d   = r_step;
          dz_d    = (d_q == '0);
        end
      end
      // IDLE and DONE both accept a new start, giving back-to-back operation.
      default: begin
        state_d = IDLE;
        if (start) begin
          q_d   = a;
          d_d   = b;
          r_d   = '0;
          cnt_d = CW'(WIDTH - 1);
          if (early) begin
            state_d = DONE;
            quo_d   = (b == '0) ? '1 : '0;
            rem_d   = a;
            dz_d    = (b == '0);
          end else begin
            state_d = CALC;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_div88_seq.sv
// Directed table-driven bench for div88_seq plus hand-written handshake, abort and back-to-back sequences.
module tb_div88_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, dz;
  logic [7:0] quo, rem;

  div88_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quo(quo), .rem(rem), .dz(dz)
  );

  always #5 clk = ~clk;

`ifdef DIV88_EARLY_EXIT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         quo;
    int         rem;
    int         dz;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_early(input logic [7:0] x, input logic [7:0] y);
    return EARLY_EN && ((y == 8'd0) || (x < y));
  endfunction

  // Edges after the capture edge until done is seen; busy cycles counted on the way.
  task automatic wait_done(input string name, input int exp_lat, output int lat, output int busy_cyc);
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cyc++;
      tick();
      lat++;
    end
    chk({name, " latency"}, lat, exp_lat);
  endtask

  task automatic run_div(input string name, input logic [7:0] x, input logic [7:0] y,
                         input int eq, input int er, input int edz);
    int lat, bc, el;
    el = is_early(x, y) ? 0 : 8;
    a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(name, el, lat, bc);
    chk({name, " busy cycles"}, bc, el);
    chk({name, " quo"}, int'(quo), eq);
    chk({name, " rem"}, int'(rem), er);
    chk({name, " dz"}, int'(dz), edz);
    tick();
    chk({name, " done pulse width"}, int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];
    int   lat, bc, el, pulses, hold_bad, rq, rr;

    vt[0] = '{8'd200, 8'd7,   28,  4,   0};
    vt[1] = '{8'd255, 8'd1,   255, 0,   0};
    vt[2] = '{8'd5,   8'd9,   0,   5,   0};
    vt[3] = '{8'd100, 8'd0,   255, 100, 1};
    vt[4] = '{8'd81,  8'd9,   9,   0,   0};
    vt[5] = '{8'd0,   8'd5,   0,   0,   0};
    vt[6] = '{8'd255, 8'd255, 1,   0,   0};
    vt[7] = '{8'd254, 8'd16,  15,  14,  0};
    vt[8] = '{8'd1,   8'd255, 0,   1,   0};
    vt[9] = '{8'd0,   8'd0,   255, 0,   1};

    rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset quo", int'(quo), 0);
      chk("reset rem", int'(rem), 0);
      chk("reset dz", int'(dz), 0);
    end

    for (int i = 0; i < 10; i++) begin
      run_div($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].quo, vt[i].rem, vt[i].dz);
    end

    // Back-to-back: second start presented in the done cycle of the first.
    a = 8'd255; b = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("b2b first", 8, lat, bc);
    chk("b2b first quo", int'(quo), 255);
    chk("b2b first rem", int'(rem), 0);
    a = 8'd5; b = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    el = is_early(8'd5, 8'd9) ? 0 : 8;
    wait_done("b2b second", el, lat, bc);
    chk("b2b second busy cycles", bc, el);
    chk("b2b second quo", int'(quo), 0);
    chk("b2b second rem", int'(rem), 5);
    tick();

    // Start toggling and operand churn while busy must be ignored; outputs hold during CALC.
    a = 8'd200; b = 8'd7; start = 1'b1;
    tick();
    pulses = 0; hold_bad = 0; rq = -1; rr = -1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        pulses++;
        rq = int'(quo);
        rr = int'(rem);
      end
      if (busy) begin
        if (quo != 8'd0 || rem != 8'd5) hold_bad++;
        start = ~start;
        a = 8'($urandom);
        b = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("churn done pulses", pulses, 1);
    chk("churn outputs held during calc", hold_bad, 0);
    chk("churn quo", rq, 28);
    chk("churn rem", rr, 4);

    // Asynchronous abort in the 4th CALC cycle.
    a = 8'd200; b = 8'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("abort busy before rst", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort quo", int'(quo), 0);
    chk("abort rem", int'(rem), 0);
    chk("abort dz", int'(dz), 0);
    tick(); tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("abort no done pulse", pulses, 0);
    run_div("after abort", 8'd81, 8'd9, 9, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
